// File: rtl/lut_neuron_scheduler_if.sv
// lut_neuron_scheduler_if: frame stream, output stream and configuration port of the LUT neuron scheduler
//   in_valid/in_ready/in_data     input frame handshake, 2-bit features packed LSB-first
//   out_valid/out_ready/out_data  output vector handshake, 2-bit neuron results packed LSB-first
//   cfg_we/cfg_sel/cfg_addr/cfg_data  truth-table / fan-in map write port
//   cfg_err                       sticky rejected-write flag
`timescale 1ns/1ps
interface lut_neuron_scheduler_if #(
  parameter int NUM_NEURONS  = 8,
  parameter int NUM_FEATURES = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [2*NUM_FEATURES-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*NUM_NEURONS-1:0]  out_data;
  logic                      cfg_we;
  logic                      cfg_sel;
  logic [15:0]               cfg_addr;
  logic [7:0]                cfg_data;
  logic                      cfg_err;
  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_err
  );
  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_err
  );
endinterface

// File: rtl/lut_neuron_scheduler.sv
// lut_neuron_scheduler: time-multiplexed evaluator of fan-in-4, 2-bit-output LUT neurons sharing one truth-table memory
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (table contents are kept)
//   bus    slave side of lut_neuron_scheduler_if (frame in, vector out, config port, cfg_err)
//   busy   high whenever the FSM is not in IDLE
`timescale 1ns/1ps
module lut_neuron_scheduler #(
  parameter int NUM_NEURONS  = 8,
  parameter int NUM_FEATURES = 16,
  parameter int FANIN        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lut_neuron_scheduler_if.slave   bus,
  output logic                    busy
);
  localparam int NB = $clog2(NUM_NEURONS);
  localparam int CW = NB + 1;
  localparam int FW = $clog2(NUM_FEATURES);
  localparam int AW = 2 * FANIN;
  localparam int TW = $clog2(NUM_NEURONS * 256);
  typedef enum logic [1:0] {IDLE, EVAL, DRAIN, OUT} state_t;
  state_t state, state_n;
  logic [2*NUM_FEATURES-1:0] frame;
  logic [FW-1:0]             fmap [NUM_NEURONS][FANIN];
  logic [1:0]                tbl  [NUM_NEURONS*256];
  logic [CW-1:0]             cnt;
  logic [NB-1:0]             idx_r;
  logic [AW-1:0]             addr_r, lut_a;
  logic [TW-1:0]             wa, rd_a;
  logic                      pend, idle, tt_ok, map_ok, cfg_ok, last;
  assign idle          = state == IDLE;
  assign last          = cnt == CW'(NUM_NEURONS);
  assign busy          = !idle;
  assign bus.in_ready  = idle && !bus.cfg_we;
  assign bus.out_valid = state == OUT;
  assign tt_ok  = !bus.cfg_sel && bus.cfg_addr[15:8] < 8'(NUM_NEURONS);
  assign map_ok = bus.cfg_sel && bus.cfg_addr[15:2] < 14'(NUM_NEURONS) && bus.cfg_data < 8'(NUM_FEATURES);
  assign cfg_ok = idle && bus.cfg_we && (tt_ok || map_ok);
  assign wa     = TW'(bus.cfg_addr[15:8]) * TW'(256) + TW'(bus.cfg_addr[7:0]);
  assign rd_a   = TW'(idx_r) * TW'(256) + TW'(addr_r);
  // Gather the mapped features of the neuron being issued; slot s fills address bits [2s+1:2s].
  always_comb begin
    lut_a = '0;
    for (int s = 0; s < FANIN; s++) lut_a[2*s +: 2] = frame[{fmap[cnt[NB-1:0]][s], 1'b0} +: 2];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid && bus.in_ready) state_n = EVAL;
      EVAL:    if (last) state_n = DRAIN;
      DRAIN:   state_n = OUT;
      default: if (bus.out_ready) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // EVAL issues one neuron per cycle while cnt < NUM_NEURONS; the cycle after the final issue
  // retires the last result, then DRAIN spends one cycle before OUT presents the vector.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame        <= '0;
      cnt          <= '0;
      idx_r        <= '0;
      addr_r       <= '0;
      pend         <= 1'b0;
      bus.out_data <= '0;
      bus.cfg_err  <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++)
        for (int s = 0; s < FANIN; s++) fmap[n][s] <= FW'(s);
    end else begin
      pend <= 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        frame <= bus.in_data;
        cnt   <= '0;
      end
      if (state == EVAL && !last) begin
        addr_r <= lut_a;
        idx_r  <= cnt[NB-1:0];
        cnt    <= cnt + 1'b1;
        pend   <= 1'b1;
      end
      if (pend) bus.out_data[{idx_r, 1'b0} +: 2] <= tbl[rd_a];
      if (bus.cfg_we && !cfg_ok) bus.cfg_err <= 1'b1;
      if (cfg_ok && bus.cfg_sel) fmap[bus.cfg_addr[NB+1:2]][bus.cfg_addr[1:0]] <= bus.cfg_data[FW-1:0];
    end
  // Truth table has no reset so its contents survive a mid-frame reset.
  always_ff @(posedge clk)
    if (cfg_ok && !bus.cfg_sel) tbl[wa] <= bus.cfg_data[1:0];
endmodule
